inst_queue_nway: RTL
====================

// Module: inst_queue_nway
// PURPOSE
//  Parametrised N-wide in-order instruction queue between fetch and decode; generalises the
//  fixed two-slot fetch FIFO to PUSH_W-wide fill and POP_W-wide issue. Buffers {pc, inst}
//  pairs from the I-bus, presents the oldest POP_W entries to the issue stage, and retires
//  exactly the entries the issue stage accepts. Supports whole-queue flush on redirect.
// PARAMETERS
//  DEPTH    16  entries; power of two, >= 2*max(PUSH_W,POP_W)
//  PUSH_W   2   max entries written per cycle
//  POP_W    2   max entries issued per cycle (= ISSUE_NUM)
//  ADDR_W   64  pc width
//  INST_W   32  instruction width
// PORTS
//  clk        in   1               clock
//  rst        in   1               asynchronous, active-high reset
//  flush      in   1               discard all entries (branch redirect / exception)
//  push_valid in   PUSH_W          thermometer mask of valid incoming slots (bit0 oldest)
//  push_pc    in   PUSH_W*ADDR_W   pc per incoming slot
//  push_inst  in   PUSH_W*INST_W   instruction per incoming slot
//  push_ready out  1               queue can take a full PUSH_W group this cycle
//  pop_en     in   POP_W           thermometer mask of slots issued this cycle (bit0 oldest)
//  out_valid  out  POP_W           slot i holds a valid entry (thermometer)
//  out_pc     out  POP_W*ADDR_W    pc of i-th oldest entry
//  out_inst   out  POP_W*INST_W    inst of i-th oldest entry
//  count      out  $clog2(DEPTH)+1 current occupancy
// BEHAVIOUR
//  - Storage: DEPTH-entry circular array, head/tail pointers $clog2(DEPTH) bits, wrap mod
//    DEPTH; separate count register (0..DEPTH). Full = count==DEPTH, empty = count==0.
//  - Reset (async): head=tail=count=0; out_valid=0, push_ready=1; array contents don't-care.
//  - push_ready = (count <= DEPTH-PUSH_W); depends on registered count only, never on
//    pop_en (no issue->fetch combinational path). Pops in the same cycle do not raise it.
//  - Push: when push_ready, slots with push_valid set are written at tail..tail+k-1
//    (k = popcount(push_valid)); tail += k. push_valid while !push_ready is dropped; fetch
//    must hold and retry. Written entries are visible on out_* the next cycle (1-cycle latency).
//  - Pop: out_valid[i] = (count > i); out_*[i] = array[head+i], combinational from registers.
//    k = popcount(pop_en & out_valid); head += k. pop_en bits beyond out_valid are ignored.
//  - Simultaneous push+pop: count_next = count + pushed - popped; both pointers advance.
//    Wrap of head and tail past DEPTH-1 is seamless, multiple slots may straddle the wrap.
//  - Flush: highest priority; head=tail=count=0 next cycle, same-cycle push and pop dropped.
//    push_ready stays 1 during flush cycle (count unchanged until edge).
//  - Reset asserted mid-operation clears immediately regardless of push/pop/flush.
//  - Illegal (assert in sim, no RTL recovery): non-thermometer push_valid or pop_en.
// STRUCTURE
//  - Package (def_cpu.svh): fetch_entry_t {addr_t pc; inst_t inst;} and QUEUE_DEPTH constant;
//    ports may be packed fetch_entry_t [W-1:0] arrays instead of flat buses.
//  - One sub-module: popcount_therm #(W) -> count of a thermometer mask (used for push/pop).
//  - Datapath wiring: replaces fifo in pipe_if; issue_en drives pop_en, ibus valid drives push.
// TESTING
//  1 reset: assert rst mid-traffic with count=7 -> same cycle count=0, out_valid=0, push_ready=1.
//  2 fill: push 2'b11 pc 0x80000000/0x80000004 each cycle, no pop -> after 8 cycles count=16,
//    push_ready=0; 9th push dropped, count stays 16, out_pc[0]=0x80000000.
//  3 drain: from full, pop_en=2'b01 then 2'b11 -> count 15 then 13; out_pc[0] advances by 4
//    then 8; push_ready=1 once count<=14.
//  4 wrap: head at 15, push 2'b11 and pop 2'b11 each cycle for 20 cycles -> count constant,
//    pc sequence strictly +4 across index 15->0, no loss/duplication (scoreboard).
//  5 flush: count=5, flush with push 2'b11 and pop 2'b11 same cycle -> next cycle count=0,
//    out_valid=0; following push visible one cycle later.
//  6 over-pop: count=1, pop_en=2'b11 -> only one entry retired, count=0, head+1.

Source files
------------

// File: rtl/inst_queue_nway_pkg.sv
// Shared fetch/issue definitions for the N-wide instruction queue.
//   QUEUE_DEPTH   : default queue depth
//   addr_t/inst_t : default pc / instruction word types
//   fetch_entry_t : {pc, inst} pair as carried between fetch and decode
//   is_therm()    : true when a mask is a thermometer code (bit0 oldest, no holes)
package inst_queue_nway_pkg;

  localparam int unsigned QUEUE_DEPTH = 16;
  localparam int unsigned DEF_ADDR_W  = 64;
  localparam int unsigned DEF_INST_W  = 32;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_INST_W-1:0] inst_t;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  // A thermometer mask has no set bit above a clear bit: m & (m+1) == 0.
  function automatic logic is_therm(input logic [31:0] m);
    return (m & (m + 32'd1)) == '0;
  endfunction

endpackage

// File: rtl/inst_queue_nway_popcount.sv
// Population count of a slot mask, used for both push and pop amounts.
//   mask_i : W-bit slot mask
//   cnt_o  : number of set bits in mask_i
module popcount_therm #(
  parameter  int unsigned W  = 2,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  mask_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(mask_i[i]);
    end
  end

endmodule

// File: rtl/inst_queue_nway.sv
// N-wide in-order instruction queue between fetch and decode.
// Buffers {pc, inst} pairs in a DEPTH-entry circular array, presents the
// oldest POP_W entries to issue and retires exactly the accepted ones.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : discard all entries (highest priority)
//   push_valid : thermometer mask of incoming slots (bit0 oldest)
//   push_pc    : pc per incoming slot
//   push_inst  : instruction per incoming slot
//   push_ready : queue can accept a full PUSH_W group (registered count only)
//   pop_en     : thermometer mask of slots issued this cycle
//   out_valid  : out slot i holds a valid entry
//   out_pc     : pc of i-th oldest entry
//   out_inst   : inst of i-th oldest entry
//   count      : current occupancy
module inst_queue_nway
  import inst_queue_nway_pkg::*;
#(
  parameter int unsigned DEPTH  = QUEUE_DEPTH,
  parameter int unsigned PUSH_W = 2,
  parameter int unsigned POP_W  = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [PUSH_W-1:0]         push_valid,
  input  logic [PUSH_W*ADDR_W-1:0]  push_pc,
  input  logic [PUSH_W*INST_W-1:0]  push_inst,
  output logic                      push_ready,
  input  logic [POP_W-1:0]          pop_en,
  output logic [POP_W-1:0]          out_valid,
  output logic [POP_W*ADDR_W-1:0]   out_pc,
  output logic [POP_W*INST_W-1:0]   out_inst,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned PUCW = $clog2(PUSH_W + 1);
  localparam int unsigned POCW = $clog2(POP_W + 1);

  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [INST_W-1:0] mem_inst_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [PUSH_W-1:0] push_acc;
  logic [POP_W-1:0]  pop_acc;
  logic [PUCW-1:0]   push_cnt;
  logic [POCW-1:0]   pop_cnt;

  logic [PW-1:0] wr_idx [PUSH_W];
  logic [PW-1:0] rd_idx [POP_W];

  // Ready looks only at the registered count so issue never feeds fetch combinationally.
  assign push_ready = (count_q <= CW'(DEPTH - PUSH_W));
  assign count      = count_q;

  assign push_acc = (push_ready && !flush) ? push_valid : '0;
  assign pop_acc  = flush ? '0 : (pop_en & out_valid);

  popcount_therm #(.W(PUSH_W)) u_push_cnt (
    .mask_i (push_acc),
    .cnt_o  (push_cnt)
  );

  popcount_therm #(.W(POP_W)) u_pop_cnt (
    .mask_i (pop_acc),
    .cnt_o  (pop_cnt)
  );

  always_comb begin
    for (int unsigned i = 0; i < PUSH_W; i++) begin
      wr_idx[i] = tail_q + PW'(i);
    end
    for (int unsigned i = 0; i < POP_W; i++) begin
      rd_idx[i] = head_q + PW'(i);
    end
  end

  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      out_valid[i]                 = (count_q > CW'(i));
      out_pc[i*ADDR_W +: ADDR_W]   = mem_pc_q[rd_idx[i]];
      out_inst[i*INST_W +: INST_W] = mem_inst_q[rd_idx[i]];
    end
  end

  always_comb begin
    head_d  = head_q + PW'(pop_cnt);
    tail_d  = tail_q + PW'(push_cnt);
    count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Array contents need no reset; occupancy alone qualifies them.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PUSH_W; i++) begin
      if (push_acc[i]) begin
        mem_pc_q[wr_idx[i]]   <= push_pc[i*ADDR_W +: ADDR_W];
        mem_inst_q[wr_idx[i]] <= push_inst[i*INST_W +: INST_W];
      end
    end
  end

  a_push_therm : assert property (@(posedge clk) disable iff (rst) is_therm(32'(push_valid)));
  a_pop_therm  : assert property (@(posedge clk) disable iff (rst) is_therm(32'(pop_en)));

endmodule
